// File: rtl/wishbone_sram_slave_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : wishbone_sram_slave_ctrl
// Description : Wishbone classic-cycle slave in front of an on-chip
//               word-addressed RAM. Programmable wait states, byte-lane
//               writes, abort on dropped cyc/stb, error termination for
//               accesses outside the address window.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               wishbone_cyc_i/stb_i     - bus cycle / strobe
//               wishbone_we_i            - 1 = write, 0 = read
//               wishbone_addr_i          - byte address (bits [1:0] ignored)
//               wishbone_data_i          - write data
//               wishbone_sel_i           - byte lanes, sel[i] <-> data[8i+7:8i]
//               wishbone_data_o          - registered read data
//               wishbone_ack_o           - normal termination, 1-cycle pulse
//               wishbone_err_o           - error termination, 1-cycle pulse
// Revision    : 1.0 - initial release
// ============================================================================
module wishbone_sram_slave_ctrl #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    SEL_WIDTH      = DATA_WIDTH / 8,
    parameter int                    MEM_DEPTH_LOG2 = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                    WAIT_CYCLES    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wishbone_cyc_i,
    input  logic                  wishbone_stb_i,
    input  logic                  wishbone_we_i,
    input  logic [ADDR_WIDTH-1:0] wishbone_addr_i,
    input  logic [DATA_WIDTH-1:0] wishbone_data_i,
    input  logic [SEL_WIDTH-1:0]  wishbone_sel_i,
    output logic [DATA_WIDTH-1:0] wishbone_data_o,
    output logic                  wishbone_ack_o,
    output logic                  wishbone_err_o
);

    localparam int         c_WIN_LSB   = MEM_DEPTH_LOG2 + 2;
    localparam int         c_DEPTH     = 1 << MEM_DEPTH_LOG2;
    // The sampling edge is followed by one decode cycle, so the WAIT state
    // lasts WAIT_CYCLES+1 cycles and the response lands WAIT_CYCLES+1 edges
    // after the request was sampled.
    localparam logic [3:0] c_WAIT_LOAD = 4'(WAIT_CYCLES);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    logic [1:0]                r_state;
    logic [1:0]                w_state_nxt;
    logic [3:0]                r_cnt;
    logic [3:0]                w_cnt_nxt;

    // Request captured at the sampling edge
    logic                      r_we;
    logic [MEM_DEPTH_LOG2-1:0] r_idx;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic [SEL_WIDTH-1:0]      r_sel;
    logic                      r_in_win;

    logic                      r_ack;
    logic                      r_err;
    logic [DATA_WIDTH-1:0]     r_rdata;

    logic [DATA_WIDTH-1:0]     r_mem [0:c_DEPTH-1];

    logic                      w_req;
    logic                      w_in_win_now;
    logic                      w_latch;
    logic                      w_enter_resp;
    logic                      w_ram_wr;
    logic                      w_ram_rd;
    logic                      w_unused;

    assign w_req        = wishbone_cyc_i & wishbone_stb_i;
    assign w_in_win_now = (wishbone_addr_i[ADDR_WIDTH-1:c_WIN_LSB] ==
                           BASE_ADDR[ADDR_WIDTH-1:c_WIN_LSB]);
    assign w_unused     = &{1'b0, wishbone_addr_i[1:0]};

    // Next-state logic
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_latch      = 1'b0;
        w_enter_resp = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_req) begin
                    w_latch     = 1'b1;
                    w_state_nxt = c_ST_WAIT;
                    w_cnt_nxt   = c_WAIT_LOAD;
                end
            end
            c_ST_WAIT: begin
                // A master that withdraws its request abandons the transfer.
                if (!w_req) begin
                    w_state_nxt = c_ST_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else if (r_cnt == 4'd0) begin
                    w_state_nxt  = c_ST_RESP;
                    w_enter_resp = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            c_ST_RESP: begin
                // The still-asserted request belongs to this finished
                // transfer, so IDLE is entered without re-sampling it.
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = 4'd0;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    assign w_ram_wr = w_enter_resp &  r_in_win &  r_we;
    assign w_ram_rd = w_enter_resp &  r_in_win & ~r_we;

    // State register and response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= 4'd0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ack   <= w_enter_resp &  r_in_win;
            r_err   <= w_enter_resp & ~r_in_win;
            if (w_ram_rd) begin
                r_rdata <= r_mem[r_idx];
            end
        end
    end

    // Request capture; only meaningful while a transfer is in flight.
    always_ff @(posedge clk) begin
        if (w_latch) begin
            r_we     <= wishbone_we_i;
            r_idx    <= wishbone_addr_i[c_WIN_LSB-1:2];
            r_wdata  <= wishbone_data_i;
            r_sel    <= wishbone_sel_i;
            r_in_win <= w_in_win_now;
        end
    end

    // RAM array: contents survive reset, but a reset edge blocks the write
    // of a transfer that would otherwise complete on that edge.
    always_ff @(posedge clk) begin
        if (!rst && w_ram_wr) begin
            for (int i = 0; i < SEL_WIDTH; i++) begin
                if (r_sel[i]) begin
                    r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

    assign wishbone_data_o = r_rdata;
    assign wishbone_ack_o  = r_ack;
    assign wishbone_err_o  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_wishbone_sram_slave_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_wishbone_sram_slave_ctrl
// Description : Self-checking bench for wishbone_sram_slave_ctrl. Three
//               instances (WAIT_CYCLES 2, 0, 3; the second at a non-zero
//               window base) share clock, reset and data-path inputs; each
//               has its own cyc/stb so only one is addressed at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wishbone_sram_slave_ctrl;

    localparam int          c_WAIT [3] = '{2, 0, 3};
    localparam logic [31:0] c_BASE [3] = '{32'h0000_0000, 32'h0000_4000, 32'h0000_0000};
    localparam int          c_WIN_BYTES = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  cyc = '0;
    logic [2:0]  stb = '0;
    logic        we  = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  sel = '0;
    logic [2:0]  ack_v;
    logic [2:0]  err_v;
    logic [31:0] dout_v [3];

    // Reference model: RAM images, known-word flags and expected data_o
    logic [31:0] m_mem   [3][1024];
    bit          m_known [3][1024];
    logic [31:0] m_dout  [3];

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    wishbone_sram_slave_ctrl #(.BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(2)) u_dut0 (
        .clk(clk), .rst(rst),
        .wishbone_cyc_i(cyc[0]), .wishbone_stb_i(stb[0]), .wishbone_we_i(we),
        .wishbone_addr_i(addr), .wishbone_data_i(wdata), .wishbone_sel_i(sel),
        .wishbone_data_o(dout_v[0]), .wishbone_ack_o(ack_v[0]), .wishbone_err_o(err_v[0])
    );
    wishbone_sram_slave_ctrl #(.BASE_ADDR(32'h0000_4000), .WAIT_CYCLES(0)) u_dut1 (
        .clk(clk), .rst(rst),
        .wishbone_cyc_i(cyc[1]), .wishbone_stb_i(stb[1]), .wishbone_we_i(we),
        .wishbone_addr_i(addr), .wishbone_data_i(wdata), .wishbone_sel_i(sel),
        .wishbone_data_o(dout_v[1]), .wishbone_ack_o(ack_v[1]), .wishbone_err_o(err_v[1])
    );
    wishbone_sram_slave_ctrl #(.BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(3)) u_dut2 (
        .clk(clk), .rst(rst),
        .wishbone_cyc_i(cyc[2]), .wishbone_stb_i(stb[2]), .wishbone_we_i(we),
        .wishbone_addr_i(addr), .wishbone_data_i(wdata), .wishbone_sel_i(sel),
        .wishbone_data_o(dout_v[2]), .wishbone_ack_o(ack_v[2]), .wishbone_err_o(err_v[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit in_window(input int d, input logic [31:0] a);
        return (a >= c_BASE[d]) && ((a - c_BASE[d]) < 32'(c_WIN_BYTES));
    endfunction

    function automatic int word_index(input int d, input logic [31:0] a);
        return int'((a - c_BASE[d]) >> 2);
    endfunction

    task automatic model_write(input int d, input int idx, input logic [31:0] wd, input logic [3:0] s);
        for (int i = 0; i < 4; i++) begin
            if (s[i]) m_mem[d][idx][8*i +: 8] = wd[8*i +: 8];
        end
    endtask

    // One complete transfer starting from an idle slave. The first edge after
    // driving is the sampling edge k; the response is expected in exactly the
    // cycle after edge k+W+1. With hold=1 the master keeps the request up
    // through the response cycle.
    task automatic xfer(input int d, input bit we_b, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] s, input bit hold);
        int w;
        bit inw;
        int idx;
        w   = c_WAIT[d];
        inw = in_window(d, a);
        idx = word_index(d, a);
        we = we_b; addr = a; wdata = wd; sel = s;
        cyc[d] = 1'b1; stb[d] = 1'b1;
        @(posedge clk); #1;
        for (int n = 1; n <= w + 3; n++) begin
            @(posedge clk); #1;
            if (n == w + 1) begin
                if (inw && we_b) begin
                    model_write(d, idx, wd, s);
                    m_known[d][idx] = 1'b1;
                end
                if (inw && !we_b) m_dout[d] = m_mem[d][idx];
                if (!hold) begin cyc[d] = 1'b0; stb[d] = 1'b0; end
                chk($sformatf("dut%0d dout a=%h", d, a), dout_v[d], m_dout[d]);
            end
            if (n == w + 2 && hold) begin cyc[d] = 1'b0; stb[d] = 1'b0; end
            chk($sformatf("dut%0d ack n=%0d a=%h", d, n, a), ack_v[d], 32'(n == w + 1 && inw));
            chk($sformatf("dut%0d err n=%0d a=%h", d, n, a), err_v[d], 32'(n == w + 1 && !inw));
        end
    endtask

    initial begin
        logic [31:0] pool_addr;
        logic [31:0] ra;
        int          pidx;

        // ---- reset ----
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset ack%0d", d), ack_v[d], 32'd0);
            chk($sformatf("reset err%0d", d), err_v[d], 32'd0);
            chk($sformatf("reset dout%0d", d), dout_v[d], 32'd0);
            m_dout[d] = '0;
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // ---- full-word write then read, W=2 ----
        xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0);
        chk("t1 readback", dout_v[0], 32'hDEADBEEF);

        // ---- byte-lane write, then sel=0 write ----
        xfer(0, 1'b1, 32'h10, 32'h0000AB00, 4'b0010, 1'b0);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
        chk("t2 lane write", dout_v[0], 32'hDEADABEF);
        xfer(0, 1'b1, 32'h10, 32'h5555_5555, 4'h0, 1'b0);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0);
        chk("t2 sel0 write", dout_v[0], 32'hDEADABEF);

        // ---- abort in first WAIT cycle ----
        xfer(0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 1'b0);
        we = 1'b1; addr = 32'h20; wdata = 32'h12345678; sel = 4'hF;
        cyc[0] = 1'b1; stb[0] = 1'b1;
        @(posedge clk); #1;
        cyc[0] = 1'b0; stb[0] = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            chk("t3 abort ack", ack_v[0], 32'd0);
            chk("t3 abort err", err_v[0], 32'd0);
        end
        xfer(0, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0);
        chk("t3 old value", dout_v[0], 32'hCAFEF00D);

        // ---- out of window: first address past the window ----
        xfer(0, 1'b1, 32'h0, 32'h1111_1111, 4'hF, 1'b0);
        xfer(0, 1'b1, 32'h1000, 32'hFFFF_FFFF, 4'hF, 1'b0);
        xfer(0, 1'b0, 32'h1000, 32'h0, 4'hF, 1'b0);
        chk("t4 dout unchanged", dout_v[0], 32'hCAFEF00D);
        xfer(0, 1'b0, 32'h0, 32'h0, 4'hF, 1'b0);
        chk("t4 no alias write", dout_v[0], 32'h1111_1111);

        // ---- held strobe, two back-to-back reads ----
        we = 1'b0; addr = 32'h10; sel = 4'hF;
        cyc[0] = 1'b1; stb[0] = 1'b1;
        @(posedge clk); #1;
        for (int n = 1; n <= 2 * c_WAIT[0] + 7; n++) begin
            @(posedge clk); #1;
            if (n == c_WAIT[0] + 2) addr = 32'h20;
            if (n == c_WAIT[0] + 1)     chk("t5 first data", dout_v[0], m_mem[0][4]);
            if (n == 2 * c_WAIT[0] + 4) chk("t5 second data", dout_v[0], m_mem[0][8]);
            if (n == 2 * c_WAIT[0] + 5) begin cyc[0] = 1'b0; stb[0] = 1'b0; end
            chk($sformatf("t5 ack n=%0d", n), ack_v[0],
                32'(n == c_WAIT[0] + 1 || n == 2 * c_WAIT[0] + 4));
            chk($sformatf("t5 err n=%0d", n), err_v[0], 32'd0);
        end
        m_dout[0] = m_mem[0][8];

        // ---- W=0 instance with non-zero base ----
        xfer(1, 1'b1, 32'h4008, 32'hA1B2C3D4, 4'hF, 1'b0);
        xfer(1, 1'b0, 32'h4008, 32'h0, 4'hF, 1'b1);
        chk("t6 w0 readback", dout_v[1], 32'hA1B2C3D4);
        xfer(1, 1'b0, 32'h3FFC, 32'h0, 4'hF, 1'b0);

        // ---- W=3: reset during WAIT ----
        xfer(2, 1'b1, 32'h30, 32'hA5A5A5A5, 4'hF, 1'b0);
        we = 1'b1; addr = 32'h30; wdata = 32'h5A5A5A5A; sel = 4'hF;
        cyc[2] = 1'b1; stb[2] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; cyc[2] = 1'b0; stb[2] = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("t6 rst ack%0d", d), ack_v[d], 32'd0);
            chk($sformatf("t6 rst err%0d", d), err_v[d], 32'd0);
            chk($sformatf("t6 rst dout%0d", d), dout_v[d], 32'd0);
            m_dout[d] = '0;
        end
        for (int n = 0; n < 6; n++) begin
            @(posedge clk); #1;
            chk("t6 post-rst ack", ack_v[2], 32'd0);
        end
        xfer(2, 1'b0, 32'h30, 32'h0, 4'hF, 1'b0);
        chk("t6 word kept", dout_v[2], 32'hA5A5A5A5);

        // ---- randomized traffic against the model ----
        for (int d = 0; d < 3; d++) begin
            for (int p = 0; p < 8; p++) begin
                pool_addr = c_BASE[d] + 32'(p * 4 + 64);
                xfer(d, 1'b1, pool_addr, $urandom, 4'hF, 1'(p % 2));
            end
            for (int t = 0; t < 30; t++) begin
                pidx = $urandom_range(0, 7);
                if ($urandom_range(0, 5) == 0) begin
                    ra = (d == 1) ? c_BASE[d] - 32'($urandom_range(1, 64))
                                  : c_BASE[d] + 32'(c_WIN_BYTES) + 32'($urandom_range(0, 255));
                end else begin
                    ra = c_BASE[d] + 32'(pidx * 4 + 64) + 32'($urandom_range(0, 3));
                end
                xfer(d, 1'($urandom_range(0, 1)), ra, $urandom, 4'($urandom_range(0, 15)),
                     1'($urandom_range(0, 1)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
